// File: rtl/regmon_display_if.sv
// Register-file monitor port: the display picks an index and the register file returns its contents.
interface regmon_display_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       monitor_sel;
    logic [WIDTH-1:0] monitor_data;

    modport master (output monitor_sel, input  monitor_data);
    modport slave  (input  monitor_sel, output monitor_data);
endinterface

// File: rtl/regmon_display.sv
// Debounced next/prev buttons pick a register; its value is shown on a 4-digit muxed hex display.
// New selection reaches the display within one frame; REGMON_AUTOSCAN_EN adds a periodic auto-advance.
module regmon_display #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REFRESH_DIV     = 100000,
    parameter int SCAN_PERIOD     = 100000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_next,
    input  logic                    btn_prev,
    regmon_display_if.master        mon,
    output logic [3:0]              an,
    output logic [6:0]              seg
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RF_W = $clog2(REFRESH_DIV + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);

    // Index 0 = next, 1 = prev.
    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d, step_q, step_d;
    logic [1:0][DB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]            sel_q, sel_d;
    logic [RF_W-1:0]       ref_q, ref_d;
    logic [1:0]            dig_q, dig_d;
    logic [WIDTH-1:0]      disp_q, disp_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            nibble;

`ifdef REGMON_AUTOSCAN_EN
    localparam int SC_W = $clog2(SCAN_PERIOD + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_PERIOD - 1);
    logic [SC_W-1:0] scan_q, scan_d;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        sync1_d   = {btn_prev, btn_next};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
        step_d = deb_d & ~deb_q;

        sel_d = sel_q;
        case (step_q)
            2'b01:   sel_d = sel_q + 4'd1;
            2'b10:   sel_d = sel_q - 4'd1;
            default: sel_d = sel_q;
        endcase
`ifdef REGMON_AUTOSCAN_EN
        // A button step wins over a coincident scan tick and restarts the scan interval.
        scan_d = scan_q + 1'b1;
        if (step_q != 2'b00) begin
            scan_d = '0;
        end else if (scan_q == SC_LAST) begin
            scan_d = '0;
            sel_d  = sel_q + 4'd1;
        end
`endif

        ref_d  = ref_q + 1'b1;
        dig_d  = dig_q;
        disp_d = disp_q;
        if (ref_q == RF_LAST) begin
            ref_d = '0;
            dig_d = dig_q + 2'd1;
            if (dig_q == 2'd3) begin
                disp_d = mon.monitor_data;
            end
        end

        // an and seg both derive from the next digit index so they switch on the same edge.
        case (dig_d)
            2'd0:    nibble = disp_d[3:0];
            2'd1:    nibble = disp_d[7:4];
            2'd2:    nibble = disp_d[11:8];
            default: nibble = disp_d[15:12];
        endcase
        an_d  = ~(4'b0001 << dig_d);
        seg_d = hex7(nibble);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
            step_q    <= '0;
            sel_q     <= '0;
            ref_q     <= '0;
            dig_q     <= '0;
            disp_q    <= '0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            step_q    <= step_d;
            sel_q     <= sel_d;
            ref_q     <= ref_d;
            dig_q     <= dig_d;
            disp_q    <= disp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

`ifdef REGMON_AUTOSCAN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan_q <= '0;
        else     scan_q <= scan_d;
    end
`endif

    assign mon.monitor_sel = sel_q;
    assign an              = an_q;
    assign seg             = seg_q;
endmodule

// File: tb/tb_regmon_display.sv
// Directed bench for regmon_display with small timing parameters.
module tb_regmon_display;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int SP = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_prev;
    logic [3:0] an;
    logic [6:0] seg;
    logic [15:0] rf [16];

    regmon_display_if #(.WIDTH(16)) mon ();
    assign mon.monitor_data = rf[mon.monitor_sel];

    regmon_display #(
        .WIDTH(16), .DEBOUNCE_CYCLES(DB), .REFRESH_DIV(RD), .SCAN_PERIOD(SP)
    ) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .mon(mon), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       nx;
        logic       pv;
        logic [3:0] exp_sel;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } dig_t;

    vec_t vecs [10];
    dig_t frame_exp [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic nx, input logic pv);
        btn_next = nx;
        btn_prev = pv;
        cycles(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cycles(10);
    endtask

    task automatic wait_change(input int maxc, output int n, output bit ok);
        logic [3:0] s;
        s  = mon.monitor_sel;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            n++;
            if (mon.monitor_sel != s) ok = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] prev_an;
        logic [3:0] s0;
        bit         found;
        bit         ok;
        int         n;

        vecs[0] = '{1'b1, 1'b0, 4'd1};
        vecs[1] = '{1'b1, 1'b0, 4'd2};
        vecs[2] = '{1'b0, 1'b1, 4'd1};
        vecs[3] = '{1'b0, 1'b1, 4'd0};
        vecs[4] = '{1'b0, 1'b1, 4'd15};
        vecs[5] = '{1'b1, 1'b0, 4'd0};
        vecs[6] = '{1'b1, 1'b1, 4'd0};
        vecs[7] = '{1'b1, 1'b0, 4'd1};
        vecs[8] = '{1'b1, 1'b1, 4'd1};
        vecs[9] = '{1'b0, 1'b1, 4'd0};

        frame_exp[0] = '{4'b1110, 7'b0000000};
        frame_exp[1] = '{4'b1101, 7'b0001110};
        frame_exp[2] = '{4'b1011, 7'b1111001};
        frame_exp[3] = '{4'b0111, 7'b0001000};

        for (int i = 0; i < 16; i++) rf[i] = 16'(i) * 16'h1111;
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cycles(3);
        check("reset_sel", mon.monitor_sel, 4'd0);
        check("reset_an", an, 4'b1110);
        check("reset_seg", seg, 7'b1000000);
        rst = 1'b0;

`ifdef REGMON_AUTOSCAN_EN
        wait_change(100, n, ok);
        check("scan_first_seen", ok, 1'b1);
        s0 = mon.monitor_sel;
        wait_change(100, n, ok);
        check("scan_period", n, SP);
        check("scan_step_sel", mon.monitor_sel, s0 + 4'd1);
        s0 = mon.monitor_sel;
        cycles(52);
        btn_next = 1'b1;
        wait_change(20, n, ok);
        check("scan_btn_seen", ok, 1'b1);
        check("scan_btn_before_tick", (n >= 6 && n <= 9), 1'b1);
        check("scan_btn_sel", mon.monitor_sel, s0 + 4'd1);
        s0 = mon.monitor_sel;
        cycles(10);
        btn_next = 1'b0;
        wait_change(100, n, ok);
        check("scan_after_btn", n, SP - 10);
        check("scan_after_btn_sel", mon.monitor_sel, s0 + 4'd1);
`else
        for (int i = 0; i < 10; i++) begin
            press(vecs[i].nx, vecs[i].pv);
            check($sformatf("vec%0d_sel", i), mon.monitor_sel, vecs[i].exp_sel);
        end

        for (int i = 0; i < 16; i++) press(1'b1, 1'b0);
        check("wrap16_sel", mon.monitor_sel, 4'd0);

        for (int i = 0; i < 6; i++) begin
            btn_next = ~btn_next;
            cycles(2);
        end
        check("bounce_no_step", mon.monitor_sel, 4'd0);
        btn_next = 1'b1;
        cycles(10);
        check("bounce_one_step", mon.monitor_sel, 4'd1);
        cycles(200);
        check("hold_no_repeat", mon.monitor_sel, 4'd1);
        btn_next = 1'b0;
        cycles(10);
`endif

        for (int i = 0; i < 16; i++) rf[i] = 16'hA1F8;
        cycles(40);
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
            else prev_an = an;
        end
        check("frame_sync", found, 1'b1);
        if (found) begin
            for (int c = 0; c < 4 * RD; c++) begin
                check($sformatf("frame_an_c%0d", c), an, frame_exp[c / RD].an);
                check($sformatf("frame_seg_c%0d", c), seg, frame_exp[c / RD].seg);
                @(negedge clk);
            end
        end

`ifndef REGMON_AUTOSCAN_EN
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        check("pre_reset_sel", mon.monitor_sel, 4'd5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", mon.monitor_sel, 4'd0);
        check("async_rst_an", an, 4'b1110);
        check("async_rst_seg", seg, 7'b1000000);
        btn_next = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);
        check("held_rst_no_early", mon.monitor_sel, 4'd0);
        cycles(9);
        check("held_rst_one_step", mon.monitor_sel, 4'd1);
        cycles(30);
        check("held_rst_no_repeat", mon.monitor_sel, 4'd1);
        btn_next = 1'b0;
        cycles(10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regmon_display.md
REGMON_DISPLAY -- requirements
Module: regmon_display

Interface
REQ-001 SHALL provide parameter: WIDTH, 16, width of monitored register data (fixed 16 = four hex digits).
REQ-002 SHALL provide parameter: DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a button level.
REQ-003 SHALL provide parameter: REFRESH_DIV, 100000, clock cycles each digit is driven.
REQ-004 SHALL provide parameter: SCAN_PERIOD, 100000000, clock cycles between auto-scan steps.
REQ-005 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: btn_next  input  1  raw push-button, advance selection.
REQ-008 SHALL have port: btn_prev  input  1  raw push-button, retreat selection.
REQ-009 SHALL have port: monitor_data  input  16  contents of selected register, returned by the register file for monitor_sel.
REQ-010 SHALL have port: monitor_sel  output  4  register index presented to the register file monitor port.
REQ-011 SHALL have port: an  output  4  digit anodes, active-low, one-hot.
REQ-012 SHALL have port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A debounced 0->1 transition SHALL produce exactly one single-cycle step pulse; holding the button SHALL NOT repeat.
REQ-015 Next pulse SHALL increment monitor_sel modulo 16 (15 -> 0) on the following edge.
REQ-016 Prev pulse SHALL decrement monitor_sel modulo 16 (0 -> 15).
REQ-017 Next and prev pulses in the same cycle SHALL leave monitor_sel unchanged.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count digit index SHALL advance 0->1->2->3->0.
REQ-019 an SHALL be one-hot low on the active digit: index 0 -> 4'b1110, 3 -> 4'b0111.
REQ-020 Display value register SHALL load monitor_data at the cycle digit index wraps 3->0 (frame start), so one frame shows one coherent value.
REQ-021 Digit k SHALL show display value bits [4k+3:4k] (digit 0 = least significant nibble).
REQ-022 seg SHALL be a registered hex decode of the active nibble, standard 0-F glyphs: 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
REQ-023 an and seg SHALL change on the same clock edge (no ghosting cycle with mismatched digit/segments).
REQ-024 Latency monitor_sel change -> new value on display SHALL be at most one full frame (4*REFRESH_DIV cycles) plus 1.

Reset
REQ-025 While rst high: monitor_sel = 0, display value = 0, digit index = 0, an = 4'b1110, seg = 7'b1000000, all counters = 0, debounced levels = 0.
REQ-026 Reset mid-debounce SHALL discard the partial count; a button held across reset release SHALL produce one step after DEBOUNCE_CYCLES stable cycles.

Configuration
REQ-027 Macro REGMON_AUTOSCAN_EN defined: a scan counter SHALL increment monitor_sel (mod 16) every SCAN_PERIOD cycles; any button step pulse SHALL reset the scan counter to 0; a button pulse coinciding with a scan tick SHALL apply only the button step.
REQ-028 REGMON_AUTOSCAN_EN undefined: no scan counter SHALL be synthesized; monitor_sel changes only via buttons.

Verification (DEBOUNCE_CYCLES=4, REFRESH_DIV=8, SCAN_PERIOD=64)
REQ-029 Assert rst mid-operation with monitor_sel=5 -> immediately monitor_sel=0, an=4'b1110, seg=7'b1000000.
REQ-030 btn_next high 10 cycles, bounce toggling every 2 cycles beforehand -> exactly one increment, 0 -> 1; held 200 cycles -> still 1.
REQ-031 Single btn_prev press at monitor_sel=0 -> 15; 16 btn_next presses from 0 -> back to 0.
REQ-032 monitor_data=16'hA1F8 held -> across one frame digits 0..3 show 8,F,1,A with an 1110,1101,1011,0111, each 8 cycles.
REQ-033 Both buttons pressed in the same cycle -> monitor_sel unchanged.
REQ-034 REGMON_AUTOSCAN_EN defined, no buttons -> monitor_sel steps every 64 cycles; press at cycle 60 -> step from button, next auto step 64 cycles after press.
